// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - FETCH/EXEC1/EXEC2 instruction-cycle sequencer with instruction register
// Optional build macro: PIPE_FETCH_EN (overlaps the next fetch with the last execute cycle).
module cpu_sequencer #(
  parameter int         DATA_W  = 16,
  parameter logic [3:0] OPC_STP = 4'b0111,
  parameter int         CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EXTRA,
  input  logic [DATA_W-1:0] RAM_Q,
  input  logic              resume,
  input  logic              step_mode,
  input  logic              step,
  input  logic              can_pipeline,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic [3:0]        IR,
  output logic [DATA_W-5:0] N,
  output logic              HALTED,
  output logic              WAITING,
  output logic [CNT_W-1:0]  instr_count
);

  // One-hot encoding so every state flag output is a register bit.
  typedef enum logic [4:0] {
    S_FETCH    = 5'b00001,
    S_EXEC1    = 5'b00010,
    S_EXEC2    = 5'b00100,
    S_HALT     = 5'b01000,
    S_STEPWAIT = 5'b10000
  } state_e;

  state_e              state_q, state_d;
  logic                first_q;
  logic [3:0]          ir_q, ir_d;
  logic [DATA_W-5:0]   n_q, n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                capture;
  logic                cnt_inc;
  logic                last_exec;
  logic                pipe_ok;

  // Overlapped fetch is allowed only when free-running; otherwise the input is inert.
`ifdef PIPE_FETCH_EN
  assign pipe_ok = can_pipeline & ~step_mode;
`else
  assign pipe_ok = can_pipeline & 1'b0;
`endif

  // State register plus the first-clock marker used to sample step_mode at reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      first_q <= 1'b1;
      ir_q    <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      ir_q    <= ir_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, instruction capture and retire-count logic.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    cnt_inc   = 1'b0;
    last_exec = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Coming out of reset in step mode we park before the first fetch.
        if (first_q && step_mode) begin
          state_d = S_STEPWAIT;
        end else begin
          capture = 1'b1;
          state_d = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (ir_q == OPC_STP) begin
          cnt_inc = 1'b1;
          state_d = S_HALT;
        end else if (EXTRA) begin
          state_d = S_EXEC2;
        end else begin
          last_exec = 1'b1;
        end
      end
      S_EXEC2: begin
        last_exec = 1'b1;
      end
      S_HALT: begin
        if (resume) begin
          state_d = step_mode ? S_STEPWAIT : S_FETCH;
        end
      end
      S_STEPWAIT: begin
        if (step || !step_mode) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Final execute cycle: the instruction retires and the next one is chosen.
    if (last_exec) begin
      cnt_inc = 1'b1;
      if (pipe_ok) begin
        capture = 1'b1;
        state_d = S_EXEC1;
      end else begin
        state_d = step_mode ? S_STEPWAIT : S_FETCH;
      end
    end

    if (capture) begin
      ir_d = RAM_Q[DATA_W-1:DATA_W-4];
      n_d  = RAM_Q[DATA_W-5:0];
    end

    // Retire counter saturates instead of wrapping.
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign FETCH       = state_q[0];
  assign EXEC1       = state_q[1];
  assign EXEC2       = state_q[2];
  assign HALTED      = state_q[3];
  assign WAITING     = state_q[4];
  assign IR          = ir_q;
  assign N           = n_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer against a phase-level reference model
module tb_cpu_sequencer;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        EXTRA;
  logic [15:0] RAM_Q;
  logic        resume;
  logic        step_mode;
  logic        step;
  logic        can_pipeline;
  logic        FETCH, EXEC1, EXEC2, HALTED, WAITING;
  logic [3:0]  IR;
  logic [11:0] N;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  cpu_sequencer #(.DATA_W(16), .OPC_STP(4'b0111), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .EXTRA        (EXTRA),
    .RAM_Q        (RAM_Q),
    .resume       (resume),
    .step_mode    (step_mode),
    .step         (step),
    .can_pipeline (can_pipeline),
    .FETCH        (FETCH),
    .EXEC1        (EXEC1),
    .EXEC2        (EXEC2),
    .IR           (IR),
    .N            (N),
    .HALTED       (HALTED),
    .WAITING      (WAITING),
    .instr_count  (instr_count)
  );

  typedef enum int {P_RST, P_FETCH, P_EX1, P_EX2, P_HALT, P_WAIT} phase_t;

  typedef struct {
    logic [4:0]  flags;
    logic [3:0]  ir;
    logic [11:0] n;
    int          cnt;
    int          cyc;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  int     cycle_no = 0;

  phase_t      ph;
  logic [3:0]  m_ir;
  logic [11:0] m_n;
  int          m_cnt;

  // Flag vector {WAITING,HALTED,EXEC2,EXEC1,FETCH} expected while in a phase.
  function automatic logic [4:0] flags_of(input phase_t p);
    case (p)
      P_EX1:   return 5'b00010;
      P_EX2:   return 5'b00100;
      P_HALT:  return 5'b01000;
      P_WAIT:  return 5'b10000;
      default: return 5'b00001;
    endcase
  endfunction

  task automatic load_word();
    m_ir = RAM_Q[15:12];
    m_n  = RAM_Q[11:0];
  endtask

  task automatic bump();
    if (m_cnt < CMAX) m_cnt = m_cnt + 1;
  endtask

  // An instruction completes: count it, then either overlap the next fetch or go fetch/wait.
  task automatic finish_instr();
    bit overlap;
    bump();
    overlap = 1'b0;
`ifdef PIPE_FETCH_EN
    overlap = can_pipeline && !step_mode;
`endif
    if (overlap) begin
      load_word();
      ph = P_EX1;
    end else if (step_mode) begin
      ph = P_WAIT;
    end else begin
      ph = P_FETCH;
    end
  endtask

  task automatic model_step();
    case (ph)
      P_RST: begin
        if (step_mode) ph = P_WAIT;
        else begin load_word(); ph = P_EX1; end
      end
      P_FETCH: begin load_word(); ph = P_EX1; end
      P_EX1: begin
        if (m_ir == 4'd7) begin bump(); ph = P_HALT; end
        else if (EXTRA) ph = P_EX2;
        else finish_instr();
      end
      P_EX2: finish_instr();
      P_HALT: begin
        if (resume) begin
          if (step_mode) ph = P_WAIT;
          else ph = P_FETCH;
        end
      end
      default: begin
        if (step || !step_mode) ph = P_FETCH;
      end
    endcase
  endtask

  // One clock of stimulus: apply inputs, record expectation for this cycle, advance model.
  task automatic cyc(input bit r, input bit sm, input logic [15:0] q, input bit ex,
                     input bit rs, input bit st, input bit cp);
    reset = r; step_mode = sm; RAM_Q = q; EXTRA = ex;
    resume = rs; step = st; can_pipeline = cp;
    if (r) begin
      ph = P_RST; m_ir = 4'd0; m_n = 12'd0; m_cnt = 0;
    end
    sb.push_back('{flags_of(ph), m_ir, m_n, m_cnt, cycle_no});
    if (!r) model_step();
    cycle_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every recorded expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    logic [4:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {WAITING, HALTED, EXEC2, EXEC1, FETCH};
        total++;
        if (got !== e.flags || IR !== e.ir || N !== e.n || instr_count !== CW'(e.cnt)) begin
          bad++;
          $display("FAIL cycle%0d: flags=%b IR=%h N=%h cnt=%0d required flags=%b IR=%h N=%h cnt=%0d",
                   e.cyc, got, IR, N, instr_count, e.flags, e.ir, e.n, e.cnt);
        end
      end
    end
  end

  initial begin
    bit rsm;
    logic [3:0] opc;
    reset = 1'b1; step_mode = 1'b0; RAM_Q = 16'h0; EXTRA = 1'b0;
    resume = 1'b0; step = 1'b0; can_pipeline = 1'b0;
    ph = P_RST; m_ir = 4'd0; m_n = 12'd0; m_cnt = 0;
    @(posedge clk);
    #1;

    // ADD with EXTRA: FETCH, EXEC1, EXEC2, FETCH
    cyc(1, 0, 16'h0000, 0, 0, 0, 0);
    cyc(1, 0, 16'h0000, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 16'h2005, 1, 0, 0, 0);
    // LDI without EXTRA: no EXEC2
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h8003, 0, 0, 0, 0);
    // STP halts; held through stray steps, then resume
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h7000, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 16'h1234, 1, 0, i[0], 0);
    cyc(0, 0, 16'h1234, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h4321, 0, 0, 0, 0);
    // Step mode from reset: wait, ignore resume, step releases one instruction
    cyc(1, 1, 16'h0000, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 16'h3abc, 0, i[0], 0, 0);
    cyc(0, 1, 16'h3abc, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'h3abc, 0, 0, 0, 0);
    // Reset during EXEC2
    cyc(1, 0, 16'h0000, 0, 0, 0, 0);
    cyc(0, 0, 16'h2005, 1, 0, 0, 0);
    cyc(0, 0, 16'h2005, 1, 0, 0, 0);
    cyc(1, 0, 16'h2005, 1, 0, 0, 0);
    // LDI then ADD with can_pipeline in LDI's EXEC1
    cyc(0, 0, 16'h8003, 0, 0, 0, 0);
    cyc(0, 0, 16'h2005, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 16'h2005, 1, 0, 0, 0);
    // Long run of short instructions to reach counter saturation
    for (int i = 0; i < 40; i++) cyc(0, 0, 16'h9001, 0, 0, 0, 0);

    // Randomized traffic
    rsm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rsm = ~rsm;
      opc = ($urandom_range(0, 5) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 99) < 2, rsm, {opc, 12'($urandom)},
          $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 25, $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
